uart_msg_tx: RTL and testbench
==============================

Name: uart_msg_tx

Overview:
- Downstream consumer of the fault-detection block's Bluetooth message bytes.
- Buffers bytes written by upstream logic in a small FIFO.
- Serialises each byte as a UART 8N1 frame on the TX pin that drives the HC-05 Bluetooth module.
- Replaces fixed-delay byte holding with a write strobe plus back-pressure, so upstream can push a whole message in consecutive cycles.

Parameters:
- CLKS_PER_BIT, 434, clk_50M cycles per UART bit (115200 baud at 50 MHz); legal range ≥ 2.
- ADDR_W, 4, FIFO address width; FIFO depth = 2**ADDR_W = 16 entries.

Ports:
- clk_50M  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; wr_data is pushed on every rising edge where wr_en=1 and the FIFO is not full.
- wr_data  input  8  byte to transmit (ASCII).
- fifo_full  output  1  FIFO holds 2**ADDR_W entries.
- fifo_count  output  ADDR_W+1  number of bytes currently buffered.
- overflow  output  1  sticky; set when a write is attempted while full.
- tx  output  1  UART serial line, idle high.
- tx_busy  output  1  high while a frame is being shifted (any state other than IDLE).
- tx_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - tx=1, tx_busy=0, tx_done=0, overflow=0, fifo_count=0, fifo_full=0.
  - FIFO pointers=0, bit counter=0, baud counter=0, state=IDLE.
  - Reset mid-frame aborts the frame immediately (tx returns high without waiting for a clock) and discards all buffered bytes.
- FIFO:
  - Circular buffer; read and write pointers are ADDR_W bits and wrap from 2**ADDR_W-1 to 0.
  - full and empty are decoded from the registered count at the start of the cycle.
  - Write with wr_en=1 and full=1: byte dropped, overflow<=1. overflow clears only on reset.
  - Simultaneous push and pop: count unchanged, both pointers advance. Push only: count+1. Pop only: count-1.
  - A pop when full and a write in the same cycle: the write is still dropped, because full is evaluated pre-edge.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count>0, load shift register from the FIFO head, pop, baud counter<=0, tx<=0, go to START. Otherwise tx=1.
  - START: hold tx=0 for CLKS_PER_BIT cycles. On baud counter == CLKS_PER_BIT-1: reset baud counter, drive tx<=shift[0] (LSB first), bit index<=0, go to DATA.
  - DATA: at each bit-period end, if bit index==7, tx<=1 and go to STOP; otherwise shift right, tx<=next bit, bit index+1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At period end tx_done<=1 for one cycle. Then:
    - if count>0: pop the next byte, tx<=0, go directly to START (no idle gap);
    - else go to IDLE.
- Timing and latency:
  - Each frame is exactly 10*CLKS_PER_BIT cycles of tx.
  - A byte written at edge k into an empty FIFO with the FSM in IDLE drives tx low from edge k+1.
  - tx is registered (no combinational path from wr_data to tx).
- Baud counter width is $clog2(CLKS_PER_BIT).
- tx_busy=1 in START, DATA and STOP.

Test Plan:
- Reset and idle: hold rst_n=0 for 5 cycles, then release with no writes → tx=1, tx_busy=0, fifo_count=0, overflow=0 for 1000 cycles.
- Single byte: write 0x46 ('F') at edge k.
  - tx low over cycles k+1..k+434.
  - Data bits 0,1,1,0,0,0,1,0, each 434 cycles.
  - Stop bit high for 434 cycles.
  - tx_done pulses once, 4340 cycles after the start edge; tx_busy then drops.
- Message burst: write "FIM-CSU1-#" (0x46,0x49,0x4D,0x2D,0x43,0x53,0x55,0x31,0x2D,0x23) on 10 consecutive edges.
  - Decoded serial stream matches the message in order.
  - Total frame time is 43400 cycles with no idle-high gap between stop and next start.
  - tx_done pulses 10 times; fifo_count peaks at 9.
- Overflow: starting from idle, write 18 bytes on consecutive edges.
  - fifo_count=16 and fifo_full=1 after the 17th write.
  - The 18th byte is dropped and overflow=1.
  - 17 frames are transmitted; overflow stays 1 afterward.
- Reset mid-frame: assert rst_n=0 during the 4th data bit of the 3rd byte of a 5-byte burst.
  - tx=1 asynchronously, fifo_count=0.
  - After release, no further frames and tx_done never pulses.
- Short baud: with CLKS_PER_BIT=4, write 0xA5 → bit pattern 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; frame length 40 cycles.

Source files
------------

// File: rtl/uart_msg_tx_if.sv
// Byte-write side and serial-line status of the Bluetooth message transmitter.
// The master is the upstream message source; the slave is uart_msg_tx.
interface uart_msg_tx_if #(
  parameter int ADDR_W = 4
) ();
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              fifo_full;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic              tx;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output wr_en, wr_data,
    input  fifo_full, fifo_count, overflow, tx, tx_busy, tx_done
  );

  modport slave (
    input  wr_en, wr_data,
    output fifo_full, fifo_count, overflow, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_msg_tx.sv
// Buffered UART 8N1 transmitter feeding the HC-05 module: a small byte FIFO
// with back-pressure in front of a frame serialiser that sends back-to-back frames.
module uart_msg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 4
) (
  input  logic         clk_50M,
  input  logic         rst_n,
  uart_msg_tx_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic                full, empty, push, pop;
  logic                overflow;
  logic [BAUD_W-1:0]   baud, baud_d;
  logic [2:0]          bit_idx, bit_idx_d;
  logic [DATA_W-1:0]   shift, shift_d;
  logic                tx, tx_d;
  logic                tx_done, tx_done_d;

  // full/empty come from the registered count, so a pop cannot make room
  // for a write in the same cycle.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.wr_en && !full;

  always_ff @(posedge clk_50M) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      if (bus.wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_d;
      tx      <= tx_d;
      tx_done <= tx_done_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
    end
  end

  always_ff @(posedge clk_50M) begin
    shift <= shift_d;
  end

  // Every state is entered with baud=0 and left when baud hits BAUD_LAST,
  // which gives each bit exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d   = state;
    tx_d      = tx;
    tx_done_d = 1'b0;
    baud_d    = baud + BAUD_W'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          shift_d = mem[rd_ptr];
          pop     = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_d    = '0;
          tx_d      = shift[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift[DATA_W-1:1]};
            tx_d      = shift[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_d    = '0;
          tx_done_d = 1'b1;
          if (!empty) begin
            // Chain straight into the next start bit so a message has no idle gaps.
            shift_d = mem[rd_ptr];
            pop     = 1'b1;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

  assign bus.fifo_full  = full;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow;
  assign bus.tx         = tx;
  assign bus.tx_busy    = (state != IDLE);
  assign bus.tx_done    = tx_done;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Randomised and directed bench for uart_msg_tx: a queue-level model predicts
// FIFO occupancy and frame start cycles; a serial decoder checks every frame.
module tb_uart_msg_tx;

  localparam int N  = 16;
  localparam int NS = 434;
  localparam int NQ = 4;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50M = ~clk_50M;

  uart_msg_tx_if if_main  ();
  uart_msg_tx_if if_slow  ();
  uart_msg_tx_if if_short ();

  uart_msg_tx #(.CLKS_PER_BIT(N))  u_main  (.clk_50M(clk_50M), .rst_n(rst_n), .bus(if_main));
  uart_msg_tx #(.CLKS_PER_BIT(NS)) u_slow  (.clk_50M(clk_50M), .rst_n(rst_n), .bus(if_slow));
  uart_msg_tx #(.CLKS_PER_BIT(NQ)) u_short (.clk_50M(clk_50M), .rst_n(rst_n), .bus(if_short));

  typedef struct {
    logic [7:0] b;
    int         t;
  } frame_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] mq[$];
  frame_t     sb[$];
  int         free_at  = 0;
  bit         free_vld = 1'b0;
  bit         movf     = 1'b0;
  bit         mdone    = 1'b0;
  int         msz;
  frame_t     mfr;

  int         frames_rx = 0;
  int         done_cnt  = 0;
  int         peak      = 0;
  bit         in_frame  = 1'b0;
  int         fc, fstart, bi;
  logic [7:0] fbyte;
  frame_t     efr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[idx];
  endfunction

  // Reference model: a byte leaves the queue once the line is free, a frame
  // occupies the line for 10 bit periods, and writes beyond 16 queued bytes are lost.
  initial forever begin
    @(posedge clk_50M);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      free_at  = 0;
      free_vld = 1'b0;
      movf     = 1'b0;
      mdone    = 1'b0;
    end else begin
      msz   = mq.size();
      mdone = free_vld && (cyc == free_at);
      if (msz > 0 && cyc >= free_at) begin
        mfr.b = mq.pop_front();
        mfr.t = cyc;
        sb.push_back(mfr);
        free_at  = cyc + 10 * N;
        free_vld = 1'b1;
      end
      if (if_main.wr_en) begin
        if (msz < 16) mq.push_back(if_main.wr_data);
        else          movf = 1'b1;
      end
    end
  end

  // Status checks and serial decoder for the main instance.
  initial forever begin
    @(negedge clk_50M);
    if (!rst_n) begin
      in_frame = 1'b0;
      continue;
    end
    chk("fifo_count", 32'(if_main.fifo_count), mq.size());
    chk("fifo_full",  32'(if_main.fifo_full),  32'(mq.size() == 16));
    chk("overflow",   32'(if_main.overflow),   32'(movf));
    chk("tx_busy",    32'(if_main.tx_busy),    32'(free_vld && cyc < free_at));
    chk("tx_done",    32'(if_main.tx_done),    32'(mdone));
    if (int'(if_main.fifo_count) > peak) peak = int'(if_main.fifo_count);
    if (if_main.tx_done) done_cnt++;
    if (!in_frame) begin
      if (if_main.tx == 1'b0) begin
        in_frame = 1'b1;
        fc       = 0;
        fstart   = cyc;
      end
    end else begin
      fc++;
    end
    if (in_frame && (fc % N) == N / 2) begin
      bi = fc / N;
      if (bi == 0) begin
        chk("start_bit", 32'(if_main.tx), 0);
      end else if (bi <= 8) begin
        fbyte[3'(bi - 1)] = if_main.tx;
      end else begin
        chk("stop_bit", 32'(if_main.tx), 1);
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_frame: actual=%02h required=none (cycle %0d)", fbyte, cyc);
        end else begin
          efr = sb.pop_front();
          if (fbyte !== efr.b) begin
            n_bad++;
            $display("FAIL frame_data: actual=%02h required=%02h (cycle %0d)", fbyte, efr.b, cyc);
          end
          chk("frame_start", fstart, efr.t);
        end
        frames_rx++;
        in_frame = 1'b0;
      end
    end
  end

  task automatic send_burst(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      @(negedge clk_50M);
      if_main.wr_en   = 1'b1;
      if_main.wr_data = bytes[i];
    end
    @(negedge clk_50M);
    if_main.wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk_50M);
      if (mq.size() == 0 && cyc > free_at + 1 && !in_frame) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: actual=busy required=drained within %0d cycles", nm, budget);
    end
  endtask

  // Cycle-exact waveform check of one frame on the slow (sel=0) or short (sel=1) instance.
  task automatic wave_test(input bit sel, input int cpb, input logic [7:0] b);
    string nm;
    nm = sel ? "short" : "slow";
    @(negedge clk_50M);
    if (sel) begin if_short.wr_en = 1'b1; if_short.wr_data = b; end
    else     begin if_slow.wr_en  = 1'b1; if_slow.wr_data  = b; end
    @(negedge clk_50M);
    if_short.wr_en = 1'b0;
    if_slow.wr_en  = 1'b0;
    chk({nm, "_tx_before"}, 32'(sel ? if_short.tx : if_slow.tx), 1);
    for (int c = 0; c < 10 * cpb; c++) begin
      @(negedge clk_50M);
      chk({nm, "_tx_wave"}, 32'(sel ? if_short.tx : if_slow.tx), 32'(frame_bit(b, c / cpb)));
      chk({nm, "_busy"},    32'(sel ? if_short.tx_busy : if_slow.tx_busy), 1);
      chk({nm, "_done_low"}, 32'(sel ? if_short.tx_done : if_slow.tx_done), 0);
    end
    @(negedge clk_50M);
    chk({nm, "_done_pulse"}, 32'(sel ? if_short.tx_done : if_slow.tx_done), 1);
    chk({nm, "_busy_end"},   32'(sel ? if_short.tx_busy : if_slow.tx_busy), 0);
    chk({nm, "_tx_idle"},    32'(sel ? if_short.tx : if_slow.tx), 1);
    @(negedge clk_50M);
    chk({nm, "_done_once"},  32'(sel ? if_short.tx_done : if_slow.tx_done), 0);
  endtask

  logic [7:0] msg[$];
  logic [7:0] q18[$];
  logic [7:0] q5[$];
  int         f_snap, d_snap, skip;
  logic [7:0] rnd;

  initial begin
    if_main.wr_en  = 1'b0; if_main.wr_data  = '0;
    if_slow.wr_en  = 1'b0; if_slow.wr_data  = '0;
    if_short.wr_en = 1'b0; if_short.wr_data = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk_50M);
    rst_n = 1'b1;

    repeat (1000) @(negedge clk_50M);
    chk("idle_tx", 32'(if_main.tx), 1);
    chk("idle_frames", frames_rx, 0);

    f_snap = frames_rx;
    send_burst('{8'h46});
    wait_drain("single", 400);
    chk("single_frames", frames_rx - f_snap, 1);
    chk("single_done", done_cnt, frames_rx);

    msg = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h31, 8'h2D, 8'h23};
    f_snap = frames_rx;
    d_snap = done_cnt;
    peak   = 0;
    send_burst(msg);
    wait_drain("burst", 12 * 10 * N);
    chk("burst_frames", frames_rx - f_snap, 10);
    chk("burst_done",   done_cnt - d_snap, 10);
    chk("burst_peak",   peak, 9);

    f_snap = frames_rx;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_50M);
      if (i == 17) begin
        chk("ovf_count16", 32'(if_main.fifo_count), 16);
        chk("ovf_full",    32'(if_main.fifo_full), 1);
        chk("ovf_not_yet", 32'(if_main.overflow), 0);
      end
      if_main.wr_en   = 1'b1;
      if_main.wr_data = 8'($urandom);
    end
    @(negedge clk_50M);
    if_main.wr_en = 1'b0;
    chk("ovf_set", 32'(if_main.overflow), 1);
    wait_drain("overflow", 20 * 10 * N);
    chk("ovf_frames", frames_rx - f_snap, 17);
    chk("ovf_sticky", 32'(if_main.overflow), 1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk_50M);
      rnd = 8'($urandom);
      if_main.wr_en   = ($urandom_range(0, 3) == 0);
      if_main.wr_data = rnd;
    end
    @(negedge clk_50M);
    if_main.wr_en = 1'b0;
    wait_drain("random", 20 * 10 * N);
    chk("random_sb_empty", sb.size(), 0);
    chk("random_done", done_cnt, frames_rx);

    // Reset during data bit 3 (frame bit 4) of the third byte of a 5-byte burst.
    f_snap = frames_rx;
    for (int i = 0; i < 5; i++) q5.push_back(8'($urandom));
    send_burst(q5);
    skip = 1 + 20 * N + 4 * N + N / 2 - 4;
    repeat (skip) @(negedge clk_50M);
    chk("pre_reset_busy", 32'(if_main.tx_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_tx",    32'(if_main.tx), 1);
    chk("rst_count", 32'(if_main.fifo_count), 0);
    chk("rst_busy",  32'(if_main.tx_busy), 0);
    chk("rst_ovf",   32'(if_main.overflow), 0);
    chk("rst_frames_before", frames_rx - f_snap, 2);
    f_snap = frames_rx;
    d_snap = done_cnt;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (500) @(negedge clk_50M);
    chk("post_rst_frames", frames_rx, f_snap);
    chk("post_rst_done",   done_cnt, d_snap);
    chk("post_rst_tx",     32'(if_main.tx), 1);

    wave_test(1'b0, NS, 8'h46);
    wave_test(1'b1, NQ, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
